risc_multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the RISC core: sequences fetch/decode/execute/memory/writeback on one

---
 rtl/risc_multicycle_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_risc_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// risc_multicycle_ctrl
//
// Multi-cycle control FSM for the RISC core. One shared datapath (ALU, regfile,
// single memory port) is sequenced through FETCH / DECODE / EXEC / MEM / WB.
// The opcode/funct fields of the IR are classified in DECODE and the class is
// latched, so later states only depend on state + class (+ alu_zero in EXEC,
// + mem_ready while a memory request is outstanding). An illegal instruction
// or a memory request that stays unanswered too long parks the FSM in TRAP
// until reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode/funct3/funct7 IR fields (valid from the cycle after ir_write)
//   alu_zero            ALU result is zero (BEQ compare in EXEC)
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we      memory request and write strobe
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_write, pc_write  IR / PC load enables
//   pc_src              PC_SRC_INC / PC_SRC_BRANCH
//   alu_src_a/b, alu_op ALU operand selects and operation
//   imm_type            immediate format for the imm generator
//   reg_write, wb_src   regfile write enable and write-back source
//   instr_retired       pulse in the final cycle of every instruction
//   trap, trap_cause    sticky trap flag, 0 = illegal instr, 1 = mem timeout
//   state_o             current FSM state (debug)
// -----------------------------------------------------------------------------

package RISC_ISA_pkg;
    localparam logic [6:0] OP_R_TYPE        = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE_ARITH  = 7'b0010011;
    localparam logic [6:0] OP_LOAD          = 7'b0000011;
    localparam logic [6:0] OP_STORE         = 7'b0100011;
    localparam logic [6:0] OP_BRANCH        = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB       = 3'b000;
    localparam logic [2:0] F3_ADDI          = 3'b000;
    localparam logic [2:0] F3_WORD          = 3'b010;
    localparam logic [2:0] F3_BEQ           = 3'b000;

    localparam logic [6:0] F7_ADD           = 7'b0000000;
    localparam logic [6:0] F7_SUB           = 7'b0100000;

    localparam logic [1:0] PC_SRC_INC       = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH    = 2'b01;

    localparam logic       ALU_SRC_A_REG    = 1'b0;
    localparam logic       ALU_SRC_A_PC     = 1'b1;
    localparam logic       ALU_SRC_B_REG    = 1'b0;
    localparam logic       ALU_SRC_B_IMM    = 1'b1;

    localparam logic [2:0] ALU_ADD          = 3'b000;
    localparam logic [2:0] ALU_SUB          = 3'b001;
    localparam logic [2:0] ALU_PASS_B       = 3'b010;
    localparam logic [2:0] ALU_EQ_CHECK     = 3'b011;

    localparam logic [1:0] IMM_TYPE_I       = 2'b00;
    localparam logic [1:0] IMM_TYPE_S       = 2'b01;
    localparam logic [1:0] IMM_TYPE_B       = 2'b10;

    localparam logic [1:0] WB_SRC_ALU       = 2'b00;
    localparam logic [1:0] WB_SRC_MEM       = 2'b01;
endpackage

module risc_multicycle_ctrl
    import RISC_ISA_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] imm_type,
    output logic       reg_write,
    output logic [1:0] wb_src,
    output logic       instr_retired,
    output logic       trap,
    output logic       trap_cause,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R_ADD = 3'd0,
        CLS_R_SUB = 3'd1,
        CLS_ADDI  = 3'd2,
        CLS_LW    = 3'd3,
        CLS_SW    = 3'd4,
        CLS_BEQ   = 3'd5
    } instr_class_t;

    // Wide enough to hold MEM_TIMEOUT-1; a disabled timeout still needs one bit.
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           next_state;
    instr_class_t     instr_class;
    instr_class_t     decoded_class;
    logic             decoded_legal;
    logic [CNT_W-1:0] wait_cnt;
    logic             cause_reg;
    logic             mem_wait;
    logic             timeout_hit;
    logic             ctl_src_b;
    logic [2:0]       ctl_alu_op;
    logic [1:0]       ctl_imm;

    // A memory request is outstanding in FETCH and MEM; every such cycle without
    // mem_ready counts toward the timeout. The limit is hit when the counter
    // already holds MEM_TIMEOUT-1 and this cycle waits again, so exactly
    // MEM_TIMEOUT unanswered cycles trap, while mem_ready in that same cycle
    // still completes normally.
    assign mem_wait    = (state == ST_FETCH || state == ST_MEM) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == CNT_LIMIT);

    // Classify the IR fields. Only the exact opcode/funct combinations of the
    // supported instructions are legal; everything else sends DECODE to TRAP.
    always_comb begin
        decoded_legal = 1'b0;
        decoded_class = CLS_R_ADD;
        case (opcode)
            OP_R_TYPE: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_ADD) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_R_ADD;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_R_SUB;
                end
            end
            OP_I_TYPE_ARITH: begin
                if (funct3 == F3_ADDI) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_ADDI;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_LW;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_SW;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    decoded_legal = 1'b1;
                    decoded_class = CLS_BEQ;
                end
            end
            default: begin
                decoded_legal = 1'b0;
            end
        endcase
    end

    // ALU controls for the latched class. EXEC drives them, and MEM/WB keep
    // driving the same values so the address / result stays stable while it
    // is consumed.
    always_comb begin
        ctl_src_b  = ALU_SRC_B_IMM;
        ctl_alu_op = ALU_ADD;
        ctl_imm    = IMM_TYPE_I;
        case (instr_class)
            CLS_R_ADD: begin
                ctl_src_b = ALU_SRC_B_REG;
            end
            CLS_R_SUB: begin
                ctl_src_b  = ALU_SRC_B_REG;
                ctl_alu_op = ALU_SUB;
            end
            CLS_SW: begin
                ctl_imm = IMM_TYPE_S;
            end
            CLS_BEQ: begin
                ctl_src_b  = ALU_SRC_B_REG;
                ctl_alu_op = ALU_EQ_CHECK;
                ctl_imm    = IMM_TYPE_B;
            end
            default: begin
                ctl_src_b = ALU_SRC_B_IMM;
            end
        endcase
    end

    // State register, class latch, trap cause and memory wait counter.
    // The counter restarts whenever a new memory phase (FETCH or MEM) begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            instr_class <= CLS_R_ADD;
            wait_cnt    <= '0;
            cause_reg   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE && decoded_legal) begin
                instr_class <= decoded_class;
            end
            if (next_state == ST_TRAP && state != ST_TRAP) begin
                cause_reg <= timeout_hit;
            end
            if (next_state != state && (next_state == ST_FETCH || next_state == ST_MEM)) begin
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Next-state and output decode. Every output starts at 0; each state only
    // raises what it needs. Reset overrides everything at the end so an
    // abandoned instruction drops its memory request in the reset cycle and
    // issues no PC or register write.
    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        alu_src_a     = ALU_SRC_A_REG;
        alu_src_b     = ALU_SRC_B_REG;
        alu_op        = ALU_ADD;
        imm_type      = IMM_TYPE_I;
        reg_write     = 1'b0;
        wb_src        = WB_SRC_ALU;
        instr_retired = 1'b0;
        trap          = 1'b0;
        trap_cause    = 1'b0;
        state_o       = state;

        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = ST_DECODE;
                end else if (timeout_hit) begin
                    next_state = ST_TRAP;
                end
            end
            ST_DECODE: begin
                next_state = decoded_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                alu_src_b = ctl_src_b;
                alu_op    = ctl_alu_op;
                imm_type  = ctl_imm;
                case (instr_class)
                    CLS_LW, CLS_SW: begin
                        next_state = ST_MEM;
                    end
                    CLS_BEQ: begin
                        pc_write      = 1'b1;
                        pc_src        = alu_zero ? PC_SRC_BRANCH : PC_SRC_INC;
                        instr_retired = 1'b1;
                        next_state    = ST_FETCH;
                    end
                    default: begin
                        next_state = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                alu_src_b    = ctl_src_b;
                alu_op       = ctl_alu_op;
                imm_type     = ctl_imm;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (instr_class == CLS_SW);
                if (mem_ready) begin
                    if (instr_class == CLS_SW) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        next_state    = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (timeout_hit) begin
                    next_state = ST_TRAP;
                end
            end
            ST_WB: begin
                alu_src_b     = ctl_src_b;
                alu_op        = ctl_alu_op;
                imm_type      = ctl_imm;
                reg_write     = 1'b1;
                wb_src        = (instr_class == CLS_LW) ? WB_SRC_MEM : WB_SRC_ALU;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                next_state    = ST_FETCH;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_reg;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase

        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 1'b0;
            alu_op        = 3'b000;
            imm_type      = 2'b00;
            reg_write     = 1'b0;
            wb_src        = 2'b00;
            instr_retired = 1'b0;
            trap          = 1'b0;
            trap_cause    = 1'b0;
            state_o       = 3'd0;
        end
    end

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_risc_multicycle_ctrl
//
// Directed bench for risc_multicycle_ctrl. Inputs change just after each rising
// edge and outputs are sampled a couple of time units later. Expected values
// are written out by hand for every cycle of each scenario.
// -----------------------------------------------------------------------------

module tb_risc_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] imm_type;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       instr_retired;
    logic       trap;
    logic       trap_cause;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    risc_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_type      (imm_type),
        .reg_write     (reg_write),
        .wb_src        (wb_src),
        .instr_retired (instr_retired),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .state_o       (state_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic ready,
                                 input logic zero);
        opcode    = op;
        funct3    = f3;
        funct7    = f7;
        mem_ready = ready;
        alu_zero  = zero;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Control/handshake view: state, mem_req, mem_we, mem_addr_sel, ir_write,
    // pc_write, pc_src, reg_write, wb_src, instr_retired, trap, trap_cause.
    task automatic checkCycle(input string tag, input logic [2:0] st,
                              input logic req, input logic we, input logic sel,
                              input logic irw, input logic pcw,
                              input logic [1:0] pcs, input logic rw,
                              input logic [1:0] wbs, input logic ret,
                              input logic trp, input logic cause);
        checkOutput(tag,
            {state_o, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
             reg_write, wb_src, instr_retired, trap, trap_cause},
            {st, req, we, sel, irw, pcw, pcs, rw, wbs, ret, trp, cause});
    endtask

    // ALU view: alu_src_a, alu_src_b, alu_op, imm_type.
    task automatic checkAlu(input string tag, input logic sa, input logic sb,
                            input logic [2:0] op, input logic [1:0] imm);
        checkOutput(tag, {9'd0, alu_src_a, alu_src_b, alu_op, imm_type},
                         {9'd0, sa, sb, op, imm});
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7    = 7'd0;
        alu_zero  = 1'b1;
        mem_ready = 1'b1;

        // Reset: everything 0 even with mem_ready and alu_zero high.
        tick();
        checkCycle("reset", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        checkAlu("reset_alu", 0, 0, 3'b000, 2'b00);
        tick();
        rst = 1'b0;

        // ADD with zero-wait memory: 4 cycles.
        applyStimulus(OP_R, 3'b000, F7_ADD, 1'b1, 1'b0);
        checkCycle("add_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("add_decode", 3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("add_exec", 3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        checkAlu("add_alu", 0, 0, 3'b000, 2'b00);
        tick();
        checkCycle("add_wb", 3'd4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0, 0);
        tick();

        // SUB: same shape, alu_op SUB in EXEC.
        applyStimulus(OP_R, 3'b000, F7_SUB, 1'b1, 1'b0);
        checkCycle("sub_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("sub_decode", 3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkAlu("sub_alu", 0, 0, 3'b001, 2'b00);
        tick();
        checkCycle("sub_wb", 3'd4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0, 0);
        tick();

        // LW with two memory wait cycles: retire in cycle 7.
        applyStimulus(OP_L, 3'b010, F7_ADD, 1'b1, 1'b0);
        checkCycle("lw_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        checkAlu("lw_exec_alu", 0, 1, 3'b000, 2'b00);
        checkCycle("lw_exec", 3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        applyStimulus(OP_L, 3'b010, F7_ADD, 1'b0, 1'b0);
        checkCycle("lw_mem1", 3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        checkAlu("lw_mem_alu", 0, 1, 3'b000, 2'b00);
        tick();
        checkCycle("lw_mem2", 3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        applyStimulus(OP_L, 3'b010, F7_ADD, 1'b1, 1'b0);
        checkCycle("lw_mem3", 3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("lw_wb", 3'd4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 1, 0, 0);
        tick();

        // BEQ taken then not taken: 3 cycles each, no reg_write.
        applyStimulus(OP_B, 3'b000, F7_ADD, 1'b1, 1'b1);
        checkCycle("beq1_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        checkCycle("beq1_exec", 3'd2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 1, 0, 0);
        checkAlu("beq1_alu", 0, 0, 3'b011, 2'b10);
        tick();
        applyStimulus(OP_B, 3'b000, F7_ADD, 1'b1, 1'b0);
        checkCycle("beq0_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        checkCycle("beq0_exec", 3'd2, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1, 0, 0);
        tick();

        // ADDI whose fetch waits 15 cycles, memory answers in cycle 16.
        applyStimulus(OP_I, 3'b000, F7_ADD, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            checkCycle("fetch_wait", 3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
            tick();
        end
        applyStimulus(OP_I, 3'b000, F7_ADD, 1'b1, 1'b0);
        checkCycle("fetch_ready16", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("addi_decode", 3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkAlu("addi_alu", 0, 1, 3'b000, 2'b00);
        tick();
        checkCycle("addi_wb", 3'd4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0, 0);
        tick();

        // SW interrupted by reset while waiting in MEM.
        applyStimulus(OP_S, 3'b010, F7_ADD, 1'b1, 1'b0);
        tick();
        tick();
        checkAlu("sw_alu", 0, 1, 3'b000, 2'b01);
        tick();
        applyStimulus(OP_S, 3'b010, F7_ADD, 1'b0, 1'b0);
        checkCycle("sw_mem", 3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        rst = 1'b1;
        #1;
        checkCycle("sw_rst", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        checkCycle("post_rst_fetch", 3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);

        // Keep mem_ready low: 16 unanswered fetch cycles trap with cause 1.
        for (int i = 2; i <= 16; i++) begin
            tick();
            checkCycle("timeout_wait", 3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        end
        tick();
        checkCycle("timeout_trap", 3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1);
        applyStimulus(OP_S, 3'b010, F7_ADD, 1'b1, 1'b0);
        tick();
        checkCycle("timeout_sticky", 3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1);

        // Illegal opcode traps after DECODE with cause 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(7'b1111111, 3'b000, F7_ADD, 1'b1, 1'b0);
        checkCycle("ill_fetch", 3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("ill_decode", 3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        tick();
        checkCycle("ill_trap", 3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0);
        tick();
        tick();
        checkCycle("ill_sticky", 3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0);

        // LW encoding with the wrong funct3 is illegal too.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(OP_L, 3'b000, F7_ADD, 1'b1, 1'b0);
        tick();
        tick();
        checkCycle("lwf3_trap", 3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
